// File: rtl/bram_reader_if.sv
// Bus bundle for bram_reader: the synchronous BRAM read port and the
// valid/ready pixel stream with its sof/eol sideband.
interface bram_reader_if #(
    parameter int AW = 19
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_data;
    logic          y_valid;
    logic          y_ready;
    logic [7:0]    y_data;
    logic          y_sof;
    logic          y_eol;

    modport master (
        output rd_en, rd_addr, y_valid, y_data, y_sof, y_eol,
        input  rd_data, y_ready
    );

    modport slave (
        input  rd_en, rd_addr, y_valid, y_data, y_sof, y_eol,
        output rd_data, y_ready
    );
endinterface

// File: rtl/bram_reader.sv
// Replays a stored 1-bit frame from a 1-cycle-latency BRAM as an 8-bit
// valid/ready pixel stream, hiding read latency behind a 2-entry buffer.
module bram_reader #(
    parameter  int IMG_WIDTH    = 640,
    parameter  int IMG_HEIGHT   = 480,
    localparam int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    localparam int AW           = $clog2(TOTAL_PIXELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          playback_trigger,
    output logic          playing,
    output logic          playback_complete,
    bram_reader_if.master bus
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [AW:0]   TOTAL_A  = TOTAL_PIXELS[AW:0];
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StStreaming, StComplete} state_e;

    state_e        state_q;
    logic [AW:0]   issue_addr_q;
    logic          inflight_q;
    logic [1:0]    fifo_q;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    logic pop;
    logic issue;

    assign pop = bus.y_valid && bus.y_ready;

    // Count the read already in flight and credit this cycle's pop so the
    // buffer can never receive a third entry.
    assign issue = (state_q == StStreaming) && (issue_addr_q < TOTAL_A) &&
                   (({1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

    assign bus.rd_en   = issue;
    assign bus.rd_addr = issue_addr_q[AW-1:0];

    assign bus.y_valid = (count_q != 2'd0);
    assign bus.y_data  = (bus.y_valid && fifo_q[rd_ptr_q]) ? 8'hFF : 8'h00;
    assign bus.y_sof   = bus.y_valid && (col_q == '0) && (row_q == '0);
    assign bus.y_eol   = bus.y_valid && (col_q == COL_LAST);

    assign playing           = (state_q == StStreaming);
    assign playback_complete = (state_q == StComplete);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            issue_addr_q <= '0;
            inflight_q   <= 1'b0;
            fifo_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (playback_trigger) begin
                        state_q      <= StStreaming;
                        issue_addr_q <= '0;
                        inflight_q   <= 1'b0;
                        wr_ptr_q     <= 1'b0;
                        rd_ptr_q     <= 1'b0;
                        count_q      <= '0;
                        col_q        <= '0;
                        row_q        <= '0;
                    end
                end
                StStreaming: begin
                    if (issue) issue_addr_q <= issue_addr_q + 1'b1;
                    inflight_q <= issue;
                    if (inflight_q) begin
                        fifo_q[wr_ptr_q] <= bus.rd_data;
                        wr_ptr_q         <= ~wr_ptr_q;
                    end
                    count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
                    if (pop) begin
                        rd_ptr_q <= ~rd_ptr_q;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q   <= '0;
                                state_q <= StComplete;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                StComplete: begin
                    inflight_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_reader.sv
// Directed bench for bram_reader on a 4x3 frame: reset, timing, backpressure,
// ignored triggers, mid-frame reset and back-to-back replay.
module tb_bram_reader;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    logic playback_trigger;
    logic playing;
    logic playback_complete;
    logic mem [0:(1 << AW) - 1];

    int n_total = 0;
    int n_bad   = 0;

    bram_reader_if #(.AW(AW)) bus ();

    bram_reader #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .playback_trigger (playback_trigger),
        .playing          (playing),
        .playback_complete(playback_complete),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // One-cycle-latency BRAM read port
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [N-1:0] pat);
        for (int i = 0; i < (1 << AW); i++) mem[i] = (i < N) ? pat[i] : 1'b0;
    endtask

    // Call in an IDLE cycle; returns in the cycle where playback_complete is seen.
    task automatic run_frame(input logic [N-1:0] pat, input logic [31:0] rdy, input bit timed,
                             input bit trig_mid);
        int  hs = 0;
        int  iss_d1 = 0;
        int  iss_d2 = 0;
        int  last_pop = -10;
        bit  done = 1'b0;
        bit  stalled = 1'b0;
        logic [7:0] held_data = '0;
        logic held_sof = 1'b0;
        logic held_eol = 1'b0;
        logic [4:0] ri;
        preload(pat);
        playback_trigger = 1'b1;
        step();
        playback_trigger = 1'b0;
        check_eq("play_start", {31'd0, playing}, 1);
        check_eq("first_addr", {28'd0, bus.rd_addr}, 0);
        for (int cyc = 1; cyc < 200 && !done; cyc++) begin
            if (cyc > 1) step();
            ri = cyc[4:0];
            bus.y_ready = rdy[ri];
            playback_trigger = trig_mid && (cyc == 6);
            #1;
            if (timed) begin
                check_eq("valid_t", {31'd0, bus.y_valid}, (cyc >= 3 && cyc < 3 + N) ? 1 : 0);
                check_eq("done_t", {31'd0, playback_complete}, (cyc == 3 + N) ? 1 : 0);
            end
            check_eq("occupancy", {31'd0, bus.y_valid}, (iss_d2 - hs != 0) ? 1 : 0);
            if (iss_d2 - hs > 2) check_eq("buf_overflow", iss_d2 - hs, 2);
            if (stalled && bus.y_valid) begin
                check_eq("hold_data", {24'd0, bus.y_data}, {24'd0, held_data});
                check_eq("hold_flags", {30'd0, bus.y_sof, bus.y_eol}, {30'd0, held_sof, held_eol});
            end
            if (bus.y_valid && bus.y_ready) begin
                check_eq("pix_data", {24'd0, bus.y_data}, pat[hs] ? 255 : 0);
                check_eq("pix_sof", {31'd0, bus.y_sof}, (hs == 0) ? 1 : 0);
                check_eq("pix_eol", {31'd0, bus.y_eol}, (hs % W == W - 1) ? 1 : 0);
                hs++;
                last_pop = cyc;
            end
            stalled   = bus.y_valid && !bus.y_ready;
            held_data = bus.y_data;
            held_sof  = bus.y_sof;
            held_eol  = bus.y_eol;
            if (bus.rd_en) begin
                check_eq("rd_addr", {28'd0, bus.rd_addr}, iss_d1);
                if (iss_d1 >= N) check_eq("rd_past_end", iss_d1, N - 1);
            end
            iss_d2 = iss_d1;
            iss_d1 = iss_d1 + (bus.rd_en ? 1 : 0);
            if (playback_complete) begin
                done = 1'b1;
                check_eq("done_after_last", cyc - last_pop, 1);
                check_eq("done_playing", {31'd0, playing}, 0);
            end
        end
        playback_trigger = 1'b0;
        if (!done) check_eq("done_timeout", 0, 1);
        check_eq("handshakes", hs, N);
    endtask

    initial begin
        int hs5;
        rst = 1'b1;
        playback_trigger = 1'b0;
        bus.y_ready = 1'b0;
        preload('0);

        // Reset held 3 cycles with a trigger pulse inside it
        for (int i = 0; i < 3; i++) begin
            playback_trigger = (i == 1);
            step();
            check_eq("rst_rd_en", {31'd0, bus.rd_en}, 0);
            check_eq("rst_rd_addr", {28'd0, bus.rd_addr}, 0);
            check_eq("rst_outs", {20'd0, bus.y_valid, bus.y_data, bus.y_sof, bus.y_eol},
                     0);
            check_eq("rst_status", {30'd0, playing, playback_complete}, 0);
        end
        playback_trigger = 1'b0;
        rst = 1'b0;
        step();
        step();
        check_eq("post_rst_idle", {30'd0, bus.rd_en, playing}, 0);

        // Full frame, no backpressure, alternating 255/0
        run_frame(12'b0101_0101_0101, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();
        check_eq("done_one_cycle", {31'd0, playback_complete}, 0);
        step();

        // Backpressure with a trigger mid-frame that must be ignored
        run_frame(12'b0011_1000_1011, 32'h6D9A_3CB5, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("no_second_frame", {30'd0, bus.rd_en, playback_complete}, 0);
        end

        // Reset after 5 handshakes abandons the frame
        preload(12'b1001_0110_1101);
        playback_trigger = 1'b1;
        step();
        playback_trigger = 1'b0;
        bus.y_ready = 1'b1;
        hs5 = 0;
        for (int i = 0; i < 50 && hs5 < 5; i++) begin
            if (bus.y_valid) hs5++;
            if (hs5 < 5) step();
        end
        check_eq("mid_hs_reached", hs5, 5);
        rst = 1'b1;
        step();
        check_eq("mid_rst_valid", {31'd0, bus.y_valid}, 0);
        check_eq("mid_rst_playing", {31'd0, playing}, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("no_partial_done", {31'd0, playback_complete}, 0);
        end
        run_frame(12'b1001_0110_1101, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Back-to-back: trigger on the first IDLE cycle after COMPLETE
        step();
        check_eq("b2b_idle", {30'd0, playing, playback_complete}, 0);
        run_frame(12'b1110_0010_0111, 32'hFFFF_FFFF, 1'b1, 1'b0);

        step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
